// File: rtl/procesor_mc.sv
// rtl/procesor_mc.sv - multi-cycle accumulator core with register file, return stack and handshaked data memory
module procesor_mc #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int REG_CNT = 32,
    parameter int STACK_D = 8,
    parameter int MEM_AW  = 10
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] ins_addr,
    input  logic [DATA_W+3:0] ins_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] acc,
    output logic              halted,
    output logic [1:0]        fault
);
    localparam int INS_W = DATA_W + 4;
    localparam int RW    = $clog2(REG_CNT);
    localparam int SW    = $clog2(STACK_D);

    localparam logic [3:0] OP_NOP = 4'd0, OP_LDI = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4, OP_OR = 4'd5, OP_XOR = 4'd6, OP_MOVR = 4'd7;
    localparam logic [3:0] OP_MOVA = 4'd8, OP_LDM = 4'd9, OP_STM = 4'd10, OP_JMP = 4'd11;
    localparam logic [3:0] OP_JZ = 4'd12, OP_CALL = 4'd13, OP_RET = 4'd14, OP_HLT = 4'd15;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    state_t            state, next_state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] a;
    logic              flag_z, flag_c;
    logic [SW:0]       sp;
    logic [INS_W-1:0]  ir;
    logic [DATA_W-1:0] rf [REG_CNT];
    logic [ADDR_W-1:0] stack [STACK_D];

    logic [3:0]        op;
    logic [DATA_W-1:0] imm;
    logic [RW-1:0]     ridx;
    logic [DATA_W-1:0] rval;
    logic [ADDR_W-1:0] pc_inc, target;
    logic [SW-1:0]     top_idx;
    logic              stack_full, stack_empty;
    logic [DATA_W:0]   alu;

    assign op          = ir[INS_W-1:DATA_W];
    assign imm         = ir[DATA_W-1:0];
    assign ridx        = imm[RW-1:0];
    assign rval        = rf[ridx];
    assign pc_inc      = pc + ADDR_W'(1);
    assign target      = imm[ADDR_W-1:0];
    assign top_idx     = sp[SW-1:0] - SW'(1);
    assign stack_full  = (sp == (SW+1)'(STACK_D));
    assign stack_empty = (sp == '0);

    assign ins_addr  = pc;
    assign mem_req   = (state == S_MEM);
    assign mem_we    = (op == OP_STM);
    assign mem_addr  = imm[MEM_AW-1:0];
    assign mem_wdata = a;
    assign acc       = a;
    assign halted    = (state == S_HALT);

    // Extra top bit carries carry-out on ADD and borrow on SUB
    always_comb begin
        alu = '0;
        case (op)
            OP_ADD:  alu = {1'b0, a} + {1'b0, rval};
            OP_SUB:  alu = {1'b0, a} - {1'b0, rval};
            OP_AND:  alu = {1'b0, a & rval};
            OP_OR:   alu = {1'b0, a | rval};
            OP_XOR:  alu = {1'b0, a ^ rval};
            default: alu = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH: next_state = S_EXEC;
            S_EXEC: begin
                case (op)
                    OP_LDM, OP_STM: next_state = S_MEM;
                    OP_HLT:         next_state = S_HALT;
                    OP_CALL:        next_state = stack_full ? S_HALT : S_FETCH;
                    OP_RET:         next_state = stack_empty ? S_HALT : S_FETCH;
                    default:        next_state = S_FETCH;
                endcase
            end
            S_MEM:   next_state = mem_ack ? S_FETCH : S_MEM;
            default: next_state = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= '0;
            a      <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            sp     <= '0;
            ir     <= '0;
            fault  <= 2'd0;
        end else begin
            case (state)
                S_FETCH: ir <= ins_data;
                S_EXEC: begin
                    pc <= pc_inc;
                    case (op)
                        OP_NOP, OP_MOVR: ;
                        OP_LDI:  a <= imm;
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                            a      <= alu[DATA_W-1:0];
                            flag_z <= (alu[DATA_W-1:0] == '0);
                            flag_c <= alu[DATA_W];
                        end
                        OP_MOVA: a <= rval;
                        OP_LDM, OP_STM, OP_HLT: pc <= pc;
                        OP_JMP:  pc <= target;
                        OP_JZ:   if (flag_z) pc <= target;
                        OP_CALL: begin
                            if (stack_full) begin
                                pc    <= pc;
                                fault <= 2'd1;
                            end else begin
                                sp <= sp + (SW+1)'(1);
                                pc <= target;
                            end
                        end
                        OP_RET: begin
                            if (stack_empty) begin
                                pc    <= pc;
                                fault <= 2'd2;
                            end else begin
                                sp <= sp - (SW+1)'(1);
                                pc <= stack[top_idx];
                            end
                        end
                        default: begin
                            pc    <= pc;
                            fault <= 2'd3;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ack) begin
                        pc <= pc_inc;
                        if (op == OP_LDM) a <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Register file and return stack hold no reset value
    always_ff @(posedge clk) begin
        if (!rst && state == S_EXEC) begin
            if (op == OP_MOVR) rf[ridx] <= a;
            if (op == OP_CALL && !stack_full) stack[sp[SW-1:0]] <= pc_inc;
        end
    end
endmodule

// File: tb/tb_procesor_mc.sv
// tb/tb_procesor_mc.sv - directed self-checking bench for procesor_mc (16-bit and 8-bit builds)
module tb_procesor_mc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1;
    logic [15:0] ins_addr0;
    logic [19:0] ins_data0;
    logic        mem_req0, mem_we0, mem_ack0;
    logic [9:0]  mem_addr0;
    logic [15:0] mem_wdata0, mem_rdata0, acc0;
    logic        halted0;
    logic [1:0]  fault0;

    logic [7:0]  ins_addr1;
    logic [11:0] ins_data1;
    logic        mem_req1, mem_we1, mem_ack1;
    logic [3:0]  mem_addr1;
    logic [7:0]  mem_wdata1, mem_rdata1, acc1;
    logic        halted1;
    logic [1:0]  fault1;

    logic [19:0] rom0 [0:65535];
    logic [11:0] rom1 [0:255];
    assign ins_data0 = rom0[ins_addr0];
    assign ins_data1 = rom1[ins_addr1];
    assign mem_ack1   = 1'b0;
    assign mem_rdata1 = 8'h00;

    procesor_mc dut0 (
        .clk(clk), .rst(rst0), .ins_addr(ins_addr0), .ins_data(ins_data0),
        .mem_req(mem_req0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .mem_rdata(mem_rdata0), .mem_ack(mem_ack0), .acc(acc0), .halted(halted0), .fault(fault0)
    );

    procesor_mc #(.DATA_W(8), .ADDR_W(8), .REG_CNT(4), .STACK_D(4), .MEM_AW(4)) dut1 (
        .clk(clk), .rst(rst1), .ins_addr(ins_addr1), .ins_data(ins_data1),
        .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .mem_ack(mem_ack1), .acc(acc1), .halted(halted1), .fault(fault1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // Memory responder: acks after ack_dly wait cycles, records store traffic
    int          ack_dly = 0;
    bit          ack_en = 1'b0;
    int          wait_cnt = 0;
    int          st_cycles = 0;
    logic [9:0]  st_addr = '0;
    logic [15:0] st_wdata = '0;
    initial mem_ack0 = 1'b0;
    always @(negedge clk) begin
        if (mem_req0 && ack_en) begin
            if (mem_we0) begin
                st_cycles++;
                st_addr  = mem_addr0;
                st_wdata = mem_wdata0;
            end
            if (wait_cnt == ack_dly) begin
                mem_ack0 = 1'b1;
                wait_cnt = 0;
            end else begin
                mem_ack0 = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ack0 = 1'b0;
            wait_cnt = 0;
        end
    end

    function automatic logic [19:0] i16(input logic [3:0] op, input logic [15:0] imm);
        return {op, imm};
    endfunction

    function automatic logic [11:0] i8(input logic [3:0] op, input logic [7:0] imm);
        return {op, imm};
    endfunction

    task automatic clear_rom0();
        for (int i = 0; i < 65536; i++) rom0[i] = '0;
    endtask

    task automatic reset0();
        rst0 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst0 = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_halt0(input int max, output int n);
        n = 0;
        while (!halted0 && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("halt_reached", {31'd0, halted0}, 32'd1);
    endtask

    int n;

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        mem_rdata0 = 16'hBEEF;
        for (int i = 0; i < 256; i++) rom1[i] = '0;

        // LDI 5; MOVR 3; LDI 7; ADD 3; HLT
        clear_rom0();
        rom0[0] = i16(4'd1, 16'd5);
        rom0[1] = i16(4'd7, 16'd3);
        rom0[2] = i16(4'd1, 16'd7);
        rom0[3] = i16(4'd2, 16'd3);
        rom0[4] = i16(4'd15, 16'd0);
        reset0();
        check("rst_pc", 32'(ins_addr0), 32'd0);
        check("rst_acc", 32'(acc0), 32'd0);
        check("rst_halted", {31'd0, halted0}, 32'd0);
        check("rst_fault", 32'(fault0), 32'd0);
        check("rst_mem_req", {31'd0, mem_req0}, 32'd0);
        run_halt0(50, n);
        check("add_cycles", n, 10);
        check("add_acc", 32'(acc0), 32'd12);
        check("add_z", {31'd0, dut0.flag_z}, 32'd0);
        check("add_c", {31'd0, dut0.flag_c}, 32'd0);
        check("add_fault", 32'(fault0), 32'd0);

        // Overflowing add then JZ
        clear_rom0();
        rom0[0]     = i16(4'd1, 16'hFFFF);
        rom0[1]     = i16(4'd7, 16'd1);
        rom0[2]     = i16(4'd1, 16'd1);
        rom0[3]     = i16(4'd2, 16'd1);
        rom0[4]     = i16(4'd12, 16'h0020);
        rom0[16'h20] = i16(4'd15, 16'd0);
        reset0();
        step(8);
        check("wrap_acc", 32'(acc0), 32'd0);
        check("wrap_z", {31'd0, dut0.flag_z}, 32'd1);
        check("wrap_c", {31'd0, dut0.flag_c}, 32'd1);
        step(2);
        check("jz_pc", 32'(ins_addr0), 32'h20);
        run_halt0(10, n);

        // STM with 4 wait cycles, then LDM with no wait
        clear_rom0();
        rom0[0] = i16(4'd1, 16'h1234);
        rom0[1] = i16(4'd10, 16'h03FF);
        rom0[2] = i16(4'd9, 16'h0010);
        rom0[3] = i16(4'd15, 16'd0);
        ack_en = 1'b1;
        ack_dly = 4;
        st_cycles = 0;
        reset0();
        step(9);
        check("stm_req_cycles", st_cycles, 5);
        check("stm_addr", 32'(st_addr), 32'h3FF);
        check("stm_wdata", 32'(st_wdata), 32'h1234);
        check("stm_pc", 32'(ins_addr0), 32'd2);
        check("stm_req_drop", {31'd0, mem_req0}, 32'd0);
        ack_dly = 0;
        step(3);
        check("ldm_acc", 32'(acc0), 32'hBEEF);
        check("ldm_pc", 32'(ins_addr0), 32'd3);
        run_halt0(10, n);
        check("mem_fault", 32'(fault0), 32'd0);

        // Nine nested CALLs overflow an 8-deep stack
        clear_rom0();
        for (int i = 0; i < 9; i++) rom0[i] = i16(4'd13, 16'(i + 1));
        reset0();
        run_halt0(100, n);
        check("ovf_fault", 32'(fault0), 32'd1);
        check("ovf_cycles", n, 18);

        // RET with empty stack
        clear_rom0();
        rom0[0] = i16(4'd14, 16'd0);
        reset0();
        run_halt0(20, n);
        check("unf_fault", 32'(fault0), 32'd2);
        check("unf_cycles", n, 2);

        // CALL / RET round trip
        clear_rom0();
        rom0[0] = i16(4'd13, 16'd5);
        rom0[1] = i16(4'd15, 16'd0);
        rom0[5] = i16(4'd1, 16'd9);
        rom0[6] = i16(4'd14, 16'd0);
        reset0();
        run_halt0(30, n);
        check("call_ret_fault", 32'(fault0), 32'd0);
        check("call_ret_acc", 32'(acc0), 32'd9);
        check("call_ret_cycles", n, 8);

        // Reset while stalled in MEM with no ack
        clear_rom0();
        rom0[0] = i16(4'd1, 16'd7);
        rom0[1] = i16(4'd9, 16'd5);
        ack_en = 1'b0;
        reset0();
        step(5);
        check("stall_req", {31'd0, mem_req0}, 32'd1);
        check("stall_acc", 32'(acc0), 32'd7);
        rst0 = 1'b1;
        step(1);
        check("abort_req", {31'd0, mem_req0}, 32'd0);
        check("abort_pc", 32'(ins_addr0), 32'd0);
        check("abort_acc", 32'(acc0), 32'd0);
        check("abort_state", 32'(dut0.state), 32'd0);
        rst0 = 1'b0;

        // 8-bit build: SUB with borrow, register index wraps mod 4
        rom1[0] = i8(4'd1, 8'd3);
        rom1[1] = i8(4'd7, 8'd4);
        rom1[2] = i8(4'd1, 8'd1);
        rom1[3] = i8(4'd3, 8'd0);
        rom1[4] = i8(4'd8, 8'd8);
        rom1[5] = i8(4'd15, 8'd0);
        rst1 = 1'b1;
        step(2);
        rst1 = 1'b0;
        step(8);
        check("d8_sub_acc", 32'(acc1), 32'hFE);
        check("d8_sub_c", {31'd0, dut1.flag_c}, 32'd1);
        check("d8_sub_z", {31'd0, dut1.flag_z}, 32'd0);
        step(4);
        check("d8_mova_wrap", 32'(acc1), 32'd3);
        check("d8_halted", {31'd0, halted1}, 32'd1);
        check("d8_fault", 32'(fault1), 32'd0);
        check("d8_mem_idle", {31'd0, mem_req1}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
